// File: rtl/riscv_boot_loader_pkg.sv
// Shared definitions for the boot loader: reset levels, FSM state encoding and counter width.
package riscv_boot_loader_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    localparam int BootCntWidth = 32;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_HOLD = 3'd3,
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } boot_state_t;

endpackage

// File: rtl/riscv_boot_loader_word_assembler.sv
// Packs four accepted bytes (first byte in bits [7:0]) into a word and pulses word_valid
// for the single cycle after the fourth byte; word_data holds until the next word.
module boot_word_assembler
    import riscv_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_last,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift;

    assign word_last = (byte_cnt == 2'd3);

    // NOTE: non-blocking assignments make every register here sample pre-edge values,
    // so the shift, the counter and the output word stay consistent within one edge.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            byte_cnt   <= 2'd0;
            shift      <= 24'd0;
            word_valid <= 1'b0;
            word_data  <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= 2'd0;
                shift    <= 24'd0;
            end else if (byte_valid) begin
                shift    <= {byte_data, shift[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
                if (word_last) begin
                    word_data  <= {byte_data, shift};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/riscv_boot_loader.sv
// Boot loader: takes length / data / checksum bytes, writes words into instruction memory
// and holds the CPU in reset until the image checks out.
module riscv_boot_loader
    import riscv_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  boot_done,
    output logic                  boot_err
);

    localparam logic [BootCntWidth-1:0] CntOne   = BootCntWidth'(1);
    localparam logic [BootCntWidth-1:0] Capacity = CntOne << ADDR_WIDTH;
    localparam logic [BootCntWidth-1:0] HoldLast = BootCntWidth'(HOLD_CYCLES - 1);

    boot_state_t             state;
    logic [1:0]              len_cnt;
    logic [BootCntWidth-1:0] word_count;
    logic [BootCntWidth-1:0] word_idx;
    logic [BootCntWidth-1:0] hold_cnt;
    logic [7:0]              csum;

    logic                    accept;
    logic                    data_byte;
    logic                    asm_clear;
    logic                    word_last;
    logic [BootCntWidth-1:0] len_next;

    assign accept    = rx_valid && rx_ready;
    assign data_byte = accept && (state == S_DATA);
    assign asm_clear = (state != S_DATA);
    assign len_next  = {rx_data, word_count[BootCntWidth-1:8]};

    boot_word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (data_byte),
        .byte_data  (rx_data),
        .word_last  (word_last),
        .word_valid (mem_we),
        .word_data  (mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= S_LEN;
            len_cnt    <= 2'd0;
            word_count <= '0;
            word_idx   <= '0;
            hold_cnt   <= '0;
            csum       <= 8'd0;
            mem_addr   <= '0;
            rx_ready   <= 1'b0;
            cpu_rst    <= RstEnable;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            case (state)
                S_LEN: begin
                    rx_ready <= 1'b1;
                    if (accept) begin
                        word_count <= len_next;
                        len_cnt    <= len_cnt + 2'd1;
                        if (len_cnt == 2'd3) begin
                            // Full 32-bit compare so huge counts cannot alias into range.
                            if (len_next > Capacity) begin
                                state    <= S_ERR;
                                rx_ready <= 1'b0;
                                boot_err <= 1'b1;
                            end else if (len_next == '0) begin
                                state <= S_CSUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum <= csum ^ rx_data;
                        if (word_last) begin
                            mem_addr <= word_idx[ADDR_WIDTH-1:0];
                            word_idx <= word_idx + CntOne;
                            if (word_idx + CntOne == word_count) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state    <= S_HOLD;
                            hold_cnt <= '0;
                        end else begin
                            state    <= S_ERR;
                            boot_err <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HoldLast) begin
                        state     <= S_RUN;
                        cpu_rst   <= RstDisable;
                        boot_done <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + CntOne;
                    end
                end
                S_RUN, S_ERR: begin
                end
                default: begin
                    state    <= S_ERR;
                    rx_ready <= 1'b0;
                    boot_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Directed-plus-random bench for riscv_boot_loader: a byte-stream model predicts writes,
// acceptance, release timing and error outcome.
module tb_riscv_boot_loader;

    localparam int AW   = 10;
    localparam int HOLD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          boot_done;
    logic          boot_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] stream[$];

    riscv_boot_loader #(
        .ADDR_WIDTH  (AW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " rx_ready"},  rx_ready,  0);
        check({tag, " mem_we"},    mem_we,    0);
        check({tag, " mem_addr"},  mem_addr,  0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
        check({tag, " cpu_rst"},   cpu_rst,   1);
        check({tag, " boot_done"}, boot_done, 0);
        check({tag, " boot_err"},  boot_err,  0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready after reset", rx_ready, 1);
        check("cpu held after reset", cpu_rst, 1);
    endtask

    task automatic start_stream(input logic [31:0] n);
        stream.delete();
        for (int i = 0; i < 4; i++) stream.push_back(n[8*i +: 8]);
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
    endtask

    task automatic add_csum(input logic [7:0] flip);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 4; i < stream.size(); i++) x ^= stream[i];
        stream.push_back(x ^ flip);
    endtask

    // Drives up to `limit` bytes of the stream with random gaps, checking every cycle.
    task automatic run_load(input int valid_pct, input int limit);
        logic [31:0] n;
        logic [7:0]  x;
        int          consumed;
        int          j;
        int          idle;
        bit          overflow;
        bit          good;
        bit          acc;
        bit          exp_we;
        bit          rel;

        n        = {stream[3], stream[2], stream[1], stream[0]};
        overflow = (n > (32'd1 << AW));
        consumed = overflow ? 4 : 4 + 4 * int'(n) + 1;
        x = 8'd0;
        if (!overflow) for (int i = 4; i < consumed - 1; i++) x ^= stream[i];
        good = !overflow && (stream[consumed-1] == x);

        j    = 0;
        idle = 0;
        while (j < consumed && j < limit) begin
            @(negedge clk);
            rx_valid = ($urandom_range(99) < valid_pct);
            rx_data  = rx_valid ? stream[j] : 8'($urandom);
            acc      = rx_valid && rx_ready;
            @(posedge clk);
            #1;
            exp_we = acc && !overflow && j >= 4 && j < consumed - 1 && ((j - 4) % 4 == 3);
            check("mem_we", mem_we, exp_we);
            if (exp_we) begin
                check("mem_addr", mem_addr, (j - 4) / 4);
                check("mem_wdata", mem_wdata, {stream[j], stream[j-1], stream[j-2], stream[j-3]});
            end
            if (acc) begin
                j++;
                idle = 0;
                if (j < consumed) check("rx_ready open", rx_ready, 1);
            end else if (++idle > 40) begin
                check("rx_ready timeout", rx_ready, 1);
                j = consumed;
            end
        end
        if (limit < consumed) return;

        check("final rx_ready", rx_ready, 0);
        check("final boot_err", boot_err, !good);
        check("final cpu_rst", cpu_rst, 1);

        for (int c = 1; c <= HOLD + 3; c++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            @(posedge clk);
            #1;
            check("post mem_we", mem_we, 0);
            check("post rx_ready", rx_ready, 0);
            rel = good && (c >= HOLD);
            check("post cpu_rst", cpu_rst, !rel);
            check("post boot_done", boot_done, rel);
            check("post boot_err", boot_err, !good);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] n;
        logic [7:0]  flip;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        do_reset();

        // Normal load, continuous.
        start_stream(2); add_word(32'h0000_0013); add_word(32'h0010_0093); add_csum(8'h00);
        run_load(100, 1 << 30);
        // Reset from S_RUN.
        do_reset();

        // Bad checksum.
        start_stream(2); add_word(32'h0000_0013); add_word(32'h0010_0093); add_csum(8'h01);
        run_load(100, 1 << 30);
        do_reset();

        // Zero length.
        start_stream(0); add_csum(8'h00);
        run_load(100, 1 << 30);
        do_reset();

        // Overflow by one word, and a count that would alias to zero if truncated.
        start_stream(1025); add_word($urandom); add_csum(8'h00);
        run_load(100, 1 << 30);
        do_reset();
        start_stream(32'h0001_0000); add_csum(8'h00);
        run_load(100, 1 << 30);
        do_reset();

        // Exactly full capacity.
        start_stream(1 << AW);
        for (int i = 0; i < (1 << AW); i++) add_word($urandom);
        add_csum(8'h00);
        run_load(100, 1 << 30);
        do_reset();

        // Gapped stream.
        start_stream(2); add_word(32'h0000_0013); add_word(32'h0010_0093); add_csum(8'h00);
        run_load(50, 1 << 30);
        do_reset();

        // Random images, random gaps, occasional corrupted checksum.
        for (int t = 0; t < 6; t++) begin
            n    = $urandom_range(1, 8);
            flip = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            start_stream(n);
            for (int i = 0; i < int'(n); i++) add_word($urandom);
            add_csum(flip);
            run_load(int'($urandom_range(40, 100)), 1 << 30);
            do_reset();
        end

        // Reset two bytes into word 1, then reload a single word.
        start_stream(2); add_word(32'h0000_0013); add_word(32'h0010_0093); add_csum(8'h00);
        run_load(100, 10);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("mid-word reset");
        do_reset();
        start_stream(1); add_word($urandom); add_csum(8'h00);
        run_load(100, 1 << 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
